cp0_exc_ctrl: RTL and testbench

Exception and interrupt controller (CP0 subset) for the pipelined MIPS core, sitting beside the M stage. It samples exception codes and external interrupt lines, holds the SR, Cause, EPC and PRId registers, and drives the fetch PC register's redirect controls. Its IntReq output forces the PC to the handler vector 0x00004180. Its EPC output is the return address used on ERET.

---
 rtl/cp0_exc_ctrl.sv | 125 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId and the fetch redirect request.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL = 32'h0000_2021,
  parameter logic [31:0] VEC_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  HWInt,
  input  logic        ExcValid,
  input  logic [4:0]  ExcCode,
  input  logic        BD,
  input  logic [31:0] PC_M,
  input  logic        ERET_M,
  input  logic        WE,
  input  logic [4:0]  Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        IntReq,
  output logic [31:0] EPC
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [29:0] r_epc;

  logic        w_timer_irq;
  logic [5:0]  w_ip_next;
  logic        w_int_pend;
  logic        w_int_req;
  logic        w_wr;
  logic        w_unused;

  // The vector address is hard-coded in the PC register; PC_M[1:0] is always masked.
  assign w_unused = ^{VEC_ADDR, PC_M[1:0]};

  assign w_ip_next  = HWInt | {5'b0_0000, w_timer_irq};
  assign w_int_pend = (|(w_ip_next & r_im)) & r_ie & ~r_exl;
  assign w_int_req  = w_int_pend | (ExcValid & ~r_exl);
  assign w_wr       = WE & ~w_int_req;

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_irq;

  assign w_timer_irq = r_timer_irq;

  // Free-running counter; a Compare write clears the pending match even on a same-edge hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
      r_timer_irq <= 1'b0;
    end else begin
      if (w_wr && (Addr == 5'd9)) r_count <= WData;
      else                        r_count <= r_count + 32'd1;
      if (w_wr && (Addr == 5'd11)) begin
        r_compare   <= WData;
        r_timer_irq <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer_irq <= 1'b1;
      end else begin
        r_timer_irq <= r_timer_irq;
      end
    end
  end
`else
  assign w_timer_irq = 1'b0;
`endif

  // Exception entry outranks mtc0 and ERET; mtc0 to SR lands before ERET clears EXL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 30'd0;
    end else begin
      r_ip <= w_ip_next;
      if (w_int_req) begin
        r_exl     <= 1'b1;
        r_bd      <= BD;
        r_exccode <= w_int_pend ? 5'd0 : ExcCode;
        r_epc     <= BD ? (PC_M[31:2] - 30'd1) : PC_M[31:2];
      end else begin
        if (WE && (Addr == 5'd12)) begin
          r_im <= WData[15:10];
          r_ie <= WData[0];
        end
        if (WE && (Addr == 5'd14)) r_epc <= WData[31:2];
        if (ERET_M)                          r_exl <= 1'b0;
        else if (WE && (Addr == 5'd12))      r_exl <= WData[1];
        else                                 r_exl <= r_exl;
      end
    end
  end

  // Register read mux.
  always_comb begin
    RData = 32'd0;
    case (Addr)
      5'd12:   RData = {16'h0000, r_im, 8'h00, r_exl, r_ie};
      5'd13:   RData = {r_bd, 15'h0000, r_ip, 3'b000, r_exccode, 2'b00};
      5'd14:   RData = {r_epc, 2'b00};
      5'd15:   RData = PRID_VAL;
`ifdef CP0_TIMER_EN
      5'd9:    RData = r_count;
      5'd11:   RData = r_compare;
`endif
      default: RData = 32'd0;
    endcase
  end

  assign IntReq = w_int_req;
  assign EPC    = {r_epc, 2'b00};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed test-plan scenarios, then random traffic
// checked cycle by cycle against a register-image reference model.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  HWInt;
  logic        ExcValid;
  logic [4:0]  ExcCode;
  logic        BD;
  logic [31:0] PC_M;
  logic        ERET_M;
  logic        WE;
  logic [4:0]  Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        IntReq;
  logic [31:0] EPC;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .HWInt(HWInt), .ExcValid(ExcValid), .ExcCode(ExcCode),
    .BD(BD), .PC_M(PC_M), .ERET_M(ERET_M), .WE(WE), .Addr(Addr), .WData(WData),
    .RData(RData), .IntReq(IntReq), .EPC(EPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: architectural register images.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] m_count, m_compare;
  logic        m_tirq;
  logic        seen_irq;
  logic [31:0] seen_rd;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_ipn();
`ifdef CP0_TIMER_EN
    return HWInt | {5'b0_0000, m_tirq};
`else
    return HWInt;
`endif
  endfunction

  function automatic logic m_pend();
    return ((m_ipn() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_pend() || (ExcValid && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_2021;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update();
    logic req, pend, wr, match;
    logic [5:0] ipn;
    if (reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
      m_count = 32'd0; m_compare = 32'd0; m_tirq = 1'b0;
    end else begin
      req = m_req(); pend = m_pend(); ipn = m_ipn();
      wr = WE && !req;
      match = (m_count == m_compare);
      m_count = (wr && Addr == 5'd9) ? WData : m_count + 32'd1;
      if (wr && Addr == 5'd11) begin
        m_compare = WData;
        m_tirq = 1'b0;
      end else if (match) begin
        m_tirq = 1'b1;
      end
      m_cause[15:10] = ipn;
      if (req) begin
        m_sr[1] = 1'b1;
        m_cause[31] = BD;
        m_cause[6:2] = pend ? 5'd0 : ExcCode;
        m_epc = {PC_M[31:2], 2'b00} - (BD ? 32'd4 : 32'd0);
      end else begin
        if (WE && Addr == 5'd12) m_sr = WData & 32'h0000_FC03;
        if (WE && Addr == 5'd14) m_epc = WData & 32'hFFFF_FFFC;
        if (ERET_M) m_sr[1] = 1'b0;
      end
    end
  endtask

  // One clock: check combinational outputs against the model, clock, advance the model.
  task automatic step();
    #1;
    seen_irq = IntReq;
    seen_rd  = RData;
    check32("intreq", {31'd0, IntReq}, {31'd0, m_req()});
    check32("rdata", RData, m_read(Addr));
    check32("epc_out", EPC, m_epc);
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; HWInt = 6'd0; ExcValid = 1'b0; ExcCode = 5'd0; BD = 1'b0;
    PC_M = 32'd0; ERET_M = 1'b0; WE = 1'b0; Addr = 5'd0; WData = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    Addr = a;
    #1;
    check32(tag, RData, exp);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    m_count = 32'd0; m_compare = 32'd0; m_tirq = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    rd(5'd15, "rst_prid", 32'h0000_2021);
    check32("rst_irq", {31'd0, IntReq}, 32'd0);

    // Interrupt entry
    idle(); WE = 1'b1; Addr = 5'd12; WData = 32'h0000_0401; step();
    idle(); HWInt = 6'b000001; PC_M = 32'h0000_1000; step();
    check32("int_irq", {31'd0, seen_irq}, 32'd1);
    rd(5'd14, "int_epc", 32'h0000_1000);
    rd(5'd12, "int_sr", 32'h0000_0403);
    rd(5'd13, "int_cause", 32'h0000_0400);
    Addr = 5'd0; step();
    check32("int_drop", {31'd0, seen_irq}, 32'd0);

    // Exception in a delay slot
    idle(); ERET_M = 1'b1; step();
    idle(); ExcValid = 1'b1; ExcCode = 5'd4; BD = 1'b1; PC_M = 32'h0000_3008; step();
    check32("exc_irq", {31'd0, seen_irq}, 32'd1);
    rd(5'd14, "exc_epc", 32'h0000_3004);
    rd(5'd13, "exc_cause", 32'h8000_0010);

    // Nested exception ignored, then ERET
    idle(); ExcValid = 1'b1; ExcCode = 5'd8; PC_M = 32'h0000_3100; step();
    check32("nest_irq", {31'd0, seen_irq}, 32'd0);
    rd(5'd14, "nest_epc", 32'h0000_3004);
    idle(); ERET_M = 1'b1; step();
    rd(5'd12, "eret_sr", 32'h0000_0401);

    // mtc0 to EPC dropped under IntReq
    idle(); ExcValid = 1'b1; ExcCode = 5'd4; PC_M = 32'h0000_5000;
    WE = 1'b1; Addr = 5'd14; WData = 32'h0000_7777; step();
    rd(5'd14, "drop_epc", 32'h0000_5000);

    // Interrupt beats exception; ERET loses to IntReq
    idle(); ERET_M = 1'b1; step();
    idle(); HWInt = 6'b000001; ExcValid = 1'b1; ExcCode = 5'd12; ERET_M = 1'b1;
    PC_M = 32'h0000_6000; step();
    rd(5'd13, "prio_cause", 32'h0000_0400);
    rd(5'd12, "prio_sr", 32'h0000_0403);
    rd(5'd14, "prio_epc", 32'h0000_6000);

    // Reset mid-handler clears EXL
    idle(); reset = 1'b1; step();
    reset = 1'b0;
    rd(5'd12, "mid_rst_sr", 32'd0);

`ifdef CP0_TIMER_EN
    begin
      logic fired;
      fired = 1'b0;
      do_reset();
      idle(); WE = 1'b1; Addr = 5'd11; WData = 32'd10; step();
      idle(); WE = 1'b1; Addr = 5'd12; WData = 32'h0000_0401; step();
      idle(); Addr = 5'd9;
      for (int i = 0; i < 40 && !fired; i++) begin
        step();
        if (seen_irq) begin
          fired = 1'b1;
          check32("tmr_count", seen_rd, 32'd11);
        end
      end
      check32("tmr_fired", {31'd0, fired}, 32'd1);
      idle(); ERET_M = 1'b1; WE = 1'b1; Addr = 5'd11; WData = 32'd5000; step();
      idle(); step();
      check32("tmr_clear", {31'd0, seen_irq}, 32'd0);
    end
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] addrs [7];
      addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
      reset    = ($urandom_range(0, 63) == 0);
      HWInt    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      ExcValid = ($urandom_range(0, 7) == 0);
      ExcCode  = 5'($urandom);
      BD       = 1'($urandom);
      PC_M     = $urandom;
      ERET_M   = ($urandom_range(0, 5) == 0);
      WE       = ($urandom_range(0, 3) == 0);
      Addr     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 6)];
      WData    = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_FC03);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
